// File: rtl/dvp_pkg.sv
// dvp_pkg: shared definitions for the DVP frame transmitter.
//   - dvp_state_e   : frame FSM states
//   - RGB565 field positions and the byte split used on the DVP bus
//   - the eight full-scale colour-bar constants used by dvp_tpg
//   - cnt_w()       : counter width helper that never returns zero
package dvp_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_VSYNC  = 3'd1,
        S_VBACK  = 3'd2,
        S_ACTIVE = 3'd3,
        S_VFRONT = 3'd4
    } dvp_state_e;

    localparam int PIX_W = 16;

    // RGB565 layout {R[4:0],G[5:0],B[4:0]}
    localparam int RGB_R_MSB = 15;
    localparam int RGB_R_LSB = 11;
    localparam int RGB_G_MSB = 10;
    localparam int RGB_G_LSB = 5;
    localparam int RGB_B_MSB = 4;
    localparam int RGB_B_LSB = 0;

    localparam logic [PIX_W-1:0] BAR_WHITE   = 16'hFFFF;
    localparam logic [PIX_W-1:0] BAR_YELLOW  = 16'hFFE0;
    localparam logic [PIX_W-1:0] BAR_CYAN    = 16'h07FF;
    localparam logic [PIX_W-1:0] BAR_GREEN   = 16'h07E0;
    localparam logic [PIX_W-1:0] BAR_MAGENTA = 16'hF81F;
    localparam logic [PIX_W-1:0] BAR_RED     = 16'hF800;
    localparam logic [PIX_W-1:0] BAR_BLUE    = 16'h001F;
    localparam logic [PIX_W-1:0] BAR_BLACK   = 16'h0000;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // First byte on the bus: {R[4:0],G[5:3]}
    function automatic logic [7:0] dvp_hi_byte(input logic [PIX_W-1:0] p);
        return {p[RGB_R_MSB:RGB_R_LSB], p[RGB_G_MSB:RGB_G_MSB-2]};
    endfunction

    // Second byte on the bus: {G[2:0],B[4:0]}
    function automatic logic [7:0] dvp_lo_byte(input logic [PIX_W-1:0] p);
        return {p[RGB_G_LSB+2:RGB_G_LSB], p[RGB_B_MSB:RGB_B_LSB]};
    endfunction

    // Bar order: white, yellow, cyan, green, magenta, red, blue, black
    function automatic logic [PIX_W-1:0] bar_rgb565(input int idx);
        logic [PIX_W-1:0] c;
        case (idx)
            0:       c = BAR_WHITE;
            1:       c = BAR_YELLOW;
            2:       c = BAR_CYAN;
            3:       c = BAR_GREEN;
            4:       c = BAR_MAGENTA;
            5:       c = BAR_RED;
            6:       c = BAR_BLUE;
            default: c = BAR_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/dvp_tpg.sv
// dvp_tpg: 8-bar colour-bar pattern generator (combinational).
// Ports:
//   i_pixel_x  in  X_W    horizontal pixel index within the active line
//   o_pix      out 16     RGB565 colour of the bar containing i_pixel_x
// Bar index = i_pixel_x*8/H_ACTIVE; indices past the active width give black.
module dvp_tpg
    import dvp_pkg::*;
#(
    parameter int H_ACTIVE = 1280,
    parameter int X_W      = 10
) (
    input  logic [X_W-1:0]   i_pixel_x,
    output logic [PIX_W-1:0] o_pix
);

    assign o_pix = bar_rgb565((int'(i_pixel_x) * 8) / H_ACTIVE);

endmodule

// File: rtl/dvp_frame_tx.sv
// dvp_frame_tx: camera-side DVP transmitter (OV5642 emulator).
// Serialises RGB565 pixels into the byte-wide DVP bus with programmable
// frame timing. Every line is L = 2*H_ACTIVE + H_BLANK pclk cycles.
// Optional build macro: DVP_TPG_EN adds i_tpg_sel and an internal
// colour-bar source (dvp_tpg).
// Ports:
//   i_pclk         pixel/byte clock, rising edge
//   i_rst          synchronous active-high reset
//   i_enable       start/continue frame generation (checked at frame end)
//   i_pix_data     RGB565 pixel, i_pix_valid qualifies it
//   o_pix_ready    pixel accepted when i_pix_valid && o_pix_ready
//   i_tpg_sel      (DVP_TPG_EN only) use the colour-bar generator
//   o_vsync/o_href/o_pdata  registered DVP bus
//   o_frame_start  one-cycle pulse in the cycle o_vsync first reads 0
//   o_underrun     sticky: an active pixel found no data
//   o_busy         FSM is not idle
module dvp_frame_tx
    import dvp_pkg::*;
#(
    parameter int H_ACTIVE    = 1280,
    parameter int H_BLANK     = 256,
    parameter int V_ACTIVE    = 720,
    parameter int VSYNC_LINES = 4,
    parameter int V_BACK      = 16,
    parameter int V_FRONT     = 4
) (
    input  logic             i_pclk,
    input  logic             i_rst,
    input  logic             i_enable,
    input  logic [PIX_W-1:0] i_pix_data,
    input  logic             i_pix_valid,
`ifdef DVP_TPG_EN
    input  logic             i_tpg_sel,
`endif
    output logic             o_pix_ready,
    output logic             o_vsync,
    output logic             o_href,
    output logic [7:0]       o_pdata,
    output logic             o_frame_start,
    output logic             o_underrun,
    output logic             o_busy
);

    localparam int L        = 2 * H_ACTIVE + H_BLANK;
    localparam int CYC_W    = cnt_w(L);
    localparam int LN_MAX_A = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
    localparam int LN_MAX_B = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
    localparam int LN_MAX   = (LN_MAX_A > LN_MAX_B) ? LN_MAX_A : LN_MAX_B;
    localparam int LN_W     = cnt_w(LN_MAX);

    dvp_state_e       r_state, w_state_nxt;
    logic [CYC_W-1:0] r_cyc, w_cyc_nxt;
    logic [LN_W-1:0]  r_line, w_line_nxt;
    logic [LN_W-1:0]  w_line_last;
    logic             w_eol;
    logic             w_eos;

    logic             r_hold_vld;
    logic [PIX_W-1:0] r_hold;
    logic [7:0]       r_lo;

    logic             w_tpg;
    logic [PIX_W-1:0] w_tpg_pix;
    logic [PIX_W-1:0] w_src_pix;
    logic             w_src_ok;
    logic             w_act_byte;
    logic             w_even;
    logic             w_consume;
    logic             w_load;

`ifdef DVP_TPG_EN
    dvp_tpg #(
        .H_ACTIVE (H_ACTIVE),
        .X_W      (CYC_W - 1)
    ) u_tpg (
        .i_pixel_x (r_cyc[CYC_W-1:1]),
        .o_pix     (w_tpg_pix)
    );
    assign w_tpg = i_tpg_sel;
`else
    assign w_tpg     = 1'b0;
    assign w_tpg_pix = '0;
`endif

    // ---------------- frame timing ----------------
    always_comb begin
        w_line_last = '0;
        case (r_state)
            S_VSYNC:  w_line_last = LN_W'(VSYNC_LINES - 1);
            S_VBACK:  w_line_last = LN_W'(V_BACK - 1);
            S_ACTIVE: w_line_last = LN_W'(V_ACTIVE - 1);
            S_VFRONT: w_line_last = LN_W'(V_FRONT - 1);
            default:  w_line_last = '0;
        endcase
    end

    assign w_eol = (r_cyc == CYC_W'(L - 1));
    assign w_eos = w_eol && (r_line == w_line_last);

    always_comb begin
        w_state_nxt = r_state;
        w_cyc_nxt   = r_cyc;
        w_line_nxt  = r_line;
        if (r_state == S_IDLE) begin
            w_cyc_nxt  = '0;
            w_line_nxt = '0;
            if (i_enable) begin
                w_state_nxt = S_VSYNC;
            end
        end else begin
            w_cyc_nxt = w_eol ? '0 : r_cyc + CYC_W'(1);
            if (w_eol) begin
                w_line_nxt = w_eos ? '0 : r_line + LN_W'(1);
            end
            if (w_eos) begin
                case (r_state)
                    S_VSYNC:  w_state_nxt = S_VBACK;
                    S_VBACK:  w_state_nxt = S_ACTIVE;
                    S_ACTIVE: w_state_nxt = S_VFRONT;
                    // i_enable is only honoured here, so frames never truncate
                    S_VFRONT: w_state_nxt = i_enable ? S_VSYNC : S_IDLE;
                    default:  w_state_nxt = S_IDLE;
                endcase
            end
        end
    end

    // ---------------- pixel handshake ----------------
    assign w_act_byte = (r_state == S_ACTIVE) && (r_cyc < CYC_W'(2 * H_ACTIVE));
    assign w_even     = w_act_byte && !r_cyc[0];
    assign w_consume  = w_even && !w_tpg;

    // Ready may assert while the holding register is being consumed, which
    // lets a new pixel land in the same cycle with no bubble.
    assign o_pix_ready = ((r_state == S_VBACK) || (r_state == S_ACTIVE)) && !w_tpg
                         && (!r_hold_vld || w_consume);
    assign w_load      = o_pix_ready && i_pix_valid;

    assign w_src_pix = w_tpg ? w_tpg_pix : r_hold;
    assign w_src_ok  = w_tpg || r_hold_vld;

    assign o_busy = (r_state != S_IDLE);

    // ---------------- registered control and bus ----------------
    always_ff @(posedge i_pclk) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_cyc         <= '0;
            r_line        <= '0;
            r_hold_vld    <= 1'b0;
            o_vsync       <= 1'b0;
            o_href        <= 1'b0;
            o_pdata       <= 8'h00;
            o_frame_start <= 1'b0;
            o_underrun    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cyc   <= w_cyc_nxt;
            r_line  <= w_line_nxt;

            if (w_load) begin
                r_hold_vld <= 1'b1;
            end else if (w_consume) begin
                r_hold_vld <= 1'b0;
            end

            o_vsync       <= (r_state == S_VSYNC);
            o_href        <= w_act_byte;
            o_frame_start <= (r_state == S_VBACK) && (r_line == '0) && (r_cyc == '0);

            if (w_even) begin
                // An empty holding register sends a black pixel and flags it
                o_pdata <= w_src_ok ? dvp_hi_byte(w_src_pix) : 8'h00;
                if (!w_src_ok) begin
                    o_underrun <= 1'b1;
                end
            end else if (w_act_byte) begin
                o_pdata <= r_lo;
            end else begin
                o_pdata <= 8'h00;
            end
        end
    end

    // ---------------- pixel data (validity tracked by r_hold_vld) ----------------
    always_ff @(posedge i_pclk) begin
        if (w_load) begin
            r_hold <= i_pix_data;
        end
        if (w_even) begin
            r_lo <= w_src_ok ? dvp_lo_byte(w_src_pix) : 8'h00;
        end
    end

endmodule

// File: tb/tb_dvp_frame_tx.sv
// Bench for dvp_frame_tx with a small frame (L = 14, 6 lines, 84 cycles).
module tb_dvp_frame_tx;

    localparam int H  = 4;
    localparam int HB = 6;
    localparam int VA = 3;
    localparam int VS = 1;
    localparam int VB = 1;
    localparam int VF = 1;
    localparam int L  = 2 * H + HB;
    localparam int FR = (VS + VB + VA + VF) * L;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        valid;
    logic [15:0] pdata_in;
    logic        tpg_sel;
    logic        o_pix_ready, o_vsync, o_href, o_frame_start, o_underrun, o_busy;
    logic [7:0]  o_pdata;

    always #5 clk = ~clk;

    dvp_frame_tx #(
        .H_ACTIVE    (H),
        .H_BLANK     (HB),
        .V_ACTIVE    (VA),
        .VSYNC_LINES (VS),
        .V_BACK      (VB),
        .V_FRONT     (VF)
    ) dut (
        .i_pclk        (clk),
        .i_rst         (rst),
        .i_enable      (en),
        .i_pix_data    (pdata_in),
        .i_pix_valid   (valid),
`ifdef DVP_TPG_EN
        .i_tpg_sel     (tpg_sel),
`endif
        .o_pix_ready   (o_pix_ready),
        .o_vsync       (o_vsync),
        .o_href        (o_href),
        .o_pdata       (o_pdata),
        .o_frame_start (o_frame_start),
        .o_underrun    (o_underrun),
        .o_busy        (o_busy)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int n;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h (n=%0d t=%0t)", name, act, exp, n, $time);
        end
    endtask

    // Colour bars as a viewer would expect them, by horizontal position
    function automatic logic [15:0] bar_exp(input int x);
        logic [15:0] t [8];
        t = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
        return t[(x * 8 / H) % 8];
    endfunction

    // ---------------- reference model: frame position arithmetic ----------------
    bit          m_on = 1'b0;
    int          m_p  = -1;        // cycle index within the frame, -1 when idle
    bit          m_hv, m_ur, m_rdy;
    logic [15:0] m_hold;
    logic [7:0]  m_lo;
    bit          e_vs, e_hr, e_fs, e_busy;
    logic [7:0]  e_pd;

    always @(posedge clk) begin
        bit          tpg, cons, act;
        int          ln, c;
        logic [15:0] px;
        tpg = 1'b0;
`ifdef DVP_TPG_EN
        tpg = tpg_sel;
`endif
        if (rst) begin
            m_on = 1'b1; m_p = -1; m_hv = 1'b0; m_ur = 1'b0; m_rdy = 1'b0; m_lo = 8'h00;
            e_vs = 1'b0; e_hr = 1'b0; e_fs = 1'b0; e_busy = 1'b0; e_pd = 8'h00;
        end else if (m_on) begin
            ln   = (m_p >= 0) ? m_p / L : -1;
            c    = (m_p >= 0) ? m_p % L : -1;
            act  = (ln >= VS + VB) && (ln < VS + VB + VA) && (c < 2 * H);
            e_vs = (ln >= 0) && (ln < VS);
            e_hr = act;
            e_fs = (m_p == VS * L);
            cons = 1'b0;
            if (act && (c % 2 == 0)) begin
                if (tpg) begin
                    px = bar_exp(c / 2);
                    e_pd = px[15:8]; m_lo = px[7:0];
                end else if (m_hv) begin
                    e_pd = m_hold[15:8]; m_lo = m_hold[7:0]; cons = 1'b1;
                end else begin
                    e_pd = 8'h00; m_lo = 8'h00; m_ur = 1'b1; cons = 1'b1;
                end
            end else if (act) begin
                e_pd = m_lo;
            end else begin
                e_pd = 8'h00;
            end
            if (m_rdy && valid) begin
                m_hold = pdata_in; m_hv = 1'b1;
            end else if (cons) begin
                m_hv = 1'b0;
            end
            if (m_p < 0 || m_p == FR - 1) m_p = en ? 0 : -1;
            else                          m_p = m_p + 1;
            e_busy = (m_p >= 0);
            ln = (m_p >= 0) ? m_p / L : -1;
            c  = (m_p >= 0) ? m_p % L : -1;
            m_rdy = !tpg && (ln >= VS) && (ln < VS + VB + VA) &&
                    (!m_hv || ((ln >= VS + VB) && (c < 2 * H) && (c % 2 == 0)));
        end
        if (m_on) begin
            #1;
            chk("m_vsync",  o_vsync,       e_vs);
            chk("m_href",   o_href,        e_hr);
            chk("m_pdata",  o_pdata,       e_pd);
            chk("m_fstart", o_frame_start, e_fs);
            chk("m_undrun", o_underrun,    m_ur);
            chk("m_busy",   o_busy,        e_busy);
            chk("m_ready",  o_pix_ready,   m_rdy);
        end
    end

    // ---------------- stimulus ----------------
    logic [15:0] src_mem [64];
    int          src_idx;
    bit          xfer, gap_on;
    int          cnt_vs, cnt_hr, cnt_fs;
    logic [7:0]  cap [24];
    int          ncap;
    logic [15:0] tbl [4];
    logic [15:0] pxv;

    task automatic tick();
        @(negedge clk);
        if (xfer) src_idx = (src_idx + 1) % 64;
        n++;
        valid    = !(gap_on && (n == 44 || n == 45));
        pdata_in = src_mem[src_idx];
        xfer     = valid && o_pix_ready;
        cnt_vs  += int'(o_vsync);
        cnt_hr  += int'(o_href);
        cnt_fs  += int'(o_frame_start);
    endtask

    task automatic tick_to(input int k);
        while (n < k) tick();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) src_mem[i] = 16'(i * 16'h1357 + 16'h0246);
        src_mem[0] = 16'hF81F;
        src_mem[1] = 16'h07E0;
        for (int i = 0; i < 24; i++) cap[i] = 8'h00;
        rst = 1'b1; en = 1'b0; valid = 1'b0; pdata_in = 16'h0000; tpg_sel = 1'b0;
        n = 0; src_idx = 0; xfer = 1'b0; gap_on = 1'b0;
        cnt_vs = 0; cnt_hr = 0; cnt_fs = 0;

        repeat (3) tick();
        chk("rst_vsync",  o_vsync, 0);
        chk("rst_href",   o_href, 0);
        chk("rst_pdata",  o_pdata, 0);
        chk("rst_fstart", o_frame_start, 0);
        chk("rst_undrun", o_underrun, 0);
        chk("rst_busy",   o_busy, 0);
        chk("rst_ready",  o_pix_ready, 0);

        // Frame 1: pixel gap causes an underrun on line 1, pixel 2
        rst = 1'b0; en = 1'b1; gap_on = 1'b1; n = -1;
        cnt_vs = 0; cnt_hr = 0; cnt_fs = 0;
        tick_to(0);  chk("f1_vs_n0", o_vsync, 0);
        tick_to(1);  chk("f1_vs_n1", o_vsync, 1);
        tick_to(14); chk("f1_vs_n14", o_vsync, 1);
        tick_to(15); chk("f1_vs_n15", o_vsync, 0); chk("f1_fs_n15", o_frame_start, 1);
        tick_to(16); chk("f1_fs_n16", o_frame_start, 0);
        tick_to(29); chk("f1_b0", o_pdata, 16'h00F8); chk("f1_href29", o_href, 1);
        tick_to(30); chk("f1_b1", o_pdata, 16'h001F);
        tick_to(31); chk("f1_b2", o_pdata, 16'h0007);
        tick_to(32); chk("f1_b3", o_pdata, 16'h00E0);
        tick_to(46); chk("f1_ur_n46", o_underrun, 0);
        tick_to(47); chk("f1_ur_hi", o_pdata, 0); chk("f1_ur_hr47", o_href, 1);
                     chk("f1_ur_n47", o_underrun, 1);
        tick_to(48); chk("f1_ur_lo", o_pdata, 0); chk("f1_ur_hr48", o_href, 1);
        tick_to(50); chk("f1_hr50", o_href, 1);
        tick_to(51); chk("f1_hr51", o_href, 0);
        tick_to(84);
        chk("f1_cnt_vs", 16'(cnt_vs), 14);
        chk("f1_cnt_hr", 16'(cnt_hr), 24);
        chk("f1_cnt_fs", 16'(cnt_fs), 1);
        chk("f1_vs_n84", o_vsync, 0);
        cnt_vs = 0; cnt_hr = 0; cnt_fs = 0;

        // Frame 2: period 84, enable dropped during the second active line
        tick_to(85);  chk("f2_vs_n85", o_vsync, 1);
        tick_to(128); en = 1'b0;
        tick_to(167); chk("f2_busy167", o_busy, 1); chk("f2_ur_sticky", o_underrun, 1);
        tick_to(168); chk("f2_busy168", o_busy, 0);
        chk("f2_cnt_vs", 16'(cnt_vs), 14);
        chk("f2_cnt_hr", 16'(cnt_hr), 24);
        chk("f2_cnt_fs", 16'(cnt_fs), 1);
        cnt_vs = 0;
        tick_to(220); chk("idle_no_vs", 16'(cnt_vs), 0); chk("idle_busy", o_busy, 0);

        // Reset in the middle of an active line, then restart
        en = 1'b1; gap_on = 1'b0; n = -1;
        tick_to(35); chk("c_href35", o_href, 1);
        rst = 1'b1;
        tick();
        chk("c_rst_vsync",  o_vsync, 0);
        chk("c_rst_href",   o_href, 0);
        chk("c_rst_pdata",  o_pdata, 0);
        chk("c_rst_undrun", o_underrun, 0);
        chk("c_rst_busy",   o_busy, 0);
        chk("c_rst_ready",  o_pix_ready, 0);
        rst = 1'b0; n = -1;
        tick_to(0);  chk("c_vs_n0", o_vsync, 0); chk("c_busy_n0", o_busy, 1);
        tick_to(1);  chk("c_vs_n1", o_vsync, 1);
        tick_to(15); chk("c_fs_n15", o_frame_start, 1);
        tick_to(20); en = 1'b0;
        for (int k = 0; k < 200 && o_busy; k++) tick();
        chk("c_end_busy", o_busy, 0);

`ifdef DVP_TPG_EN
        // Colour-bar frame captured back into pixels
        tbl[0] = 16'hFFFF; tbl[1] = 16'h07FF; tbl[2] = 16'hF81F; tbl[3] = 16'h001F;
        tpg_sel = 1'b1; en = 1'b1; n = -1; ncap = 0;
        while (n < 90) begin
            tick();
            if (n == 60) en = 1'b0;
            if (o_href === 1'b1) begin
                if (ncap < 24) cap[ncap] = o_pdata;
                ncap++;
            end
        end
        chk("tpg_nbytes", 16'(ncap), 24);
        for (int i = 0; i < 12; i++) begin
            pxv = {cap[2 * i], cap[2 * i + 1]};
            chk("tpg_pix", pxv, tbl[i % 4]);
        end
        chk("tpg_undrun", o_underrun, 0);
        tpg_sel = 1'b0;
`else
        tbl[0] = 16'h0000; tbl[1] = 16'h0000; tbl[2] = 16'h0000; tbl[3] = 16'h0000;
        ncap = 0; pxv = 16'h0000;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
